// File: rtl/rll_key_sched_lock.sv
// Sequential key-scheduled logic lock: serial key load into a shadow register,
// atomic commit to the active key, and XOR/XNOR key gates on a PIPE-deep data path.
module rll_key_sched_lock #(
    parameter int                DATA_W        = 32,
    parameter int                KEY_W         = 32,
    parameter int                SHIFT_W       = 1,
    parameter logic [KEY_W-1:0]  INV_MASK      = '0,
    parameter int                PIPE          = 1,
    parameter int                BLANK_UNKEYED = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_key_start,
    input  logic               i_key_valid,
    output logic               o_key_ready,
    input  logic [SHIFT_W-1:0] i_key_data,
    output logic               o_key_loaded,
    output logic               o_key_commit,
    output logic               o_key_err,
    input  logic               i_din_valid,
    input  logic [DATA_W-1:0]  i_din,
    output logic               o_dout_valid,
    output logic [DATA_W-1:0]  o_dout
);

    localparam int CNT_W = $clog2(KEY_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_inc;
    logic [KEY_W-1:0]   r_shadow;
    logic [KEY_W-1:0]   r_key;
    logic [KEY_W-1:0]   w_shift;
    logic               r_loaded;
    logic               r_err;
    logic               w_accept;
    logic               w_last;
    logic [DATA_W-1:0]  w_gated;
    logic [DATA_W-1:0]  w_keyed;
    logic [DATA_W-1:0]  r_pdata  [PIPE];
    logic               r_pvalid [PIPE];

    assign w_accept    = i_key_valid && o_key_ready;
    assign w_count_inc = r_count + CNT_W'(SHIFT_W);
    assign w_last      = w_accept && !i_key_start && (w_count_inc == CNT_W'(KEY_W));

    // New beat enters at the MSBs so the first bit received ends up in key[0].
    generate
        if (SHIFT_W == KEY_W) begin : g_shift_full
            assign w_shift = i_key_data;
        end else begin : g_shift_part
            assign w_shift = {i_key_data, r_shadow[KEY_W-1:SHIFT_W]};
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_key_start) w_next = S_LOAD;
            S_LOAD:   if (w_last) w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_key_ready  = 1'b0;
        o_key_commit = 1'b0;
        if (!i_rst) begin
            o_key_ready  = (r_state == S_LOAD);
            o_key_commit = (r_state == S_COMMIT);
        end
    end

    assign o_key_loaded = r_loaded;
    assign o_key_err    = r_err;

    // A restart always wins over a beat arriving in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count  <= '0;
            r_shadow <= '0;
            r_key    <= '0;
            r_loaded <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_key_start) begin
                        r_count  <= '0;
                        r_shadow <= '0;
                    end
                end
                S_LOAD: begin
                    if (i_key_start) begin
                        if (r_count != '0) begin
                            r_err    <= 1'b1;
                            r_count  <= '0;
                            r_shadow <= '0;
                        end
                    end else if (w_accept) begin
                        r_shadow <= w_shift;
                        r_count  <= w_count_inc;
                    end
                end
                S_COMMIT: begin
                    r_key    <= r_shadow;
                    r_loaded <= 1'b1;
                    r_err    <= 1'b0;
                    r_count  <= '0;
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < DATA_W; g++) begin : g_gate
            assign w_gated[g] = i_din[g] ^ r_key[g % KEY_W] ^ INV_MASK[g % KEY_W];
        end
    endgenerate

    assign w_keyed = (BLANK_UNKEYED != 0 && !r_loaded) ? '0 : w_gated;

    // Stage data is zeroed on idle cycles so dout reads 0 whenever dout_valid is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pvalid[0] <= 1'b0;
            r_pdata[0]  <= '0;
        end else begin
            r_pvalid[0] <= i_din_valid;
            r_pdata[0]  <= i_din_valid ? w_keyed : '0;
        end
    end

    generate
        for (genvar k = 1; k < PIPE; k++) begin : g_stage
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_pvalid[k] <= 1'b0;
                    r_pdata[k]  <= '0;
                end else begin
                    r_pvalid[k] <= r_pvalid[k-1];
                    r_pdata[k]  <= r_pdata[k-1];
                end
            end
        end
    endgenerate

    assign o_dout_valid = r_pvalid[PIPE-1];
    assign o_dout       = r_pdata[PIPE-1];

endmodule

// File: tb/tb_rll_key_sched_lock.sv
// Directed bench for rll_key_sched_lock: a default instance and a wide,
// nibble-loaded, XNOR-masked, 3-stage instance driven from one linear sequence.
module tb_rll_key_sched_lock;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        rst0, ks0, kv0, kr0, kl0, kc0, ke0, dv0, ov0;
    logic [0:0]  kd0;
    logic [31:0] din0, dout0;

    logic        rst1, ks1, kv1, kr1, kl1, kc1, ke1, dv1, ov1;
    logic [3:0]  kd1;
    logic [39:0] din1, dout1;

    logic [31:0] keyA;
    logic [31:0] keyB;
    logic [31:0] keyN;

    rll_key_sched_lock u_dut0 (
        .i_clk        (clk),
        .i_rst        (rst0),
        .i_key_start  (ks0),
        .i_key_valid  (kv0),
        .o_key_ready  (kr0),
        .i_key_data   (kd0),
        .o_key_loaded (kl0),
        .o_key_commit (kc0),
        .o_key_err    (ke0),
        .i_din_valid  (dv0),
        .i_din        (din0),
        .o_dout_valid (ov0),
        .o_dout       (dout0)
    );

    rll_key_sched_lock #(
        .DATA_W        (40),
        .KEY_W         (32),
        .SHIFT_W       (4),
        .INV_MASK      (32'hFFFF_FFFF),
        .PIPE          (3),
        .BLANK_UNKEYED (0)
    ) u_dut1 (
        .i_clk        (clk),
        .i_rst        (rst1),
        .i_key_start  (ks1),
        .i_key_valid  (kv1),
        .o_key_ready  (kr1),
        .i_key_data   (kd1),
        .o_key_loaded (kl1),
        .o_key_commit (kc1),
        .o_key_err    (ke1),
        .i_din_valid  (dv1),
        .i_din        (din1),
        .o_dout_valid (ov1),
        .o_dout       (dout1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One streaming data beat on dut0: the beat on din0 is keyed with ek at this edge.
    task automatic stream0(input logic [31:0] ek);
        logic [31:0] sent;
        sent = din0;
        tick();
        checkOutput("stream_valid", ov0, 1'b1);
        checkOutput("stream_dout", dout0, sent ^ ek);
        din0 = din0 + 32'h0101_0103;
    endtask

    initial begin
        keyA = 32'hA5A5_A5A5;
        keyB = 32'h3C3C_0F0F;
        keyN = 32'h8765_4321;
        rst0 = 1'b1; ks0 = 1'b0; kv0 = 1'b0; kd0 = '0; dv0 = 1'b0; din0 = '0;
        rst1 = 1'b1; ks1 = 1'b0; kv1 = 1'b0; kd1 = '0; dv1 = 1'b0; din1 = '0;
        tick();
        tick();
        checkOutput("rst_ready0", kr0, 1'b0);
        checkOutput("rst_ready1", kr1, 1'b0);
        rst0 = 1'b0;
        #1;
        checkOutput("rst_loaded0", kl0, 1'b0);
        checkOutput("rst_commit0", kc0, 1'b0);
        checkOutput("rst_err0", ke0, 1'b0);
        checkOutput("rst_ovalid0", ov0, 1'b0);
        checkOutput("rst_dout0", dout0, 32'h0);
        checkOutput("idle_ready0", kr0, 1'b0);

        // Unkeyed instance blanks data but keeps valid.
        dv0 = 1'b1; din0 = 32'h1234_5678;
        tick();
        checkOutput("blank_valid", ov0, 1'b1);
        checkOutput("blank_dout", dout0, 32'h0);
        dv0 = 1'b0;
        tick();
        checkOutput("blank_valid_off", ov0, 1'b0);

        // Serial LSB-first load of keyA.
        ks0 = 1'b1;
        tick();
        ks0 = 1'b0;
        checkOutput("load_ready0", kr0, 1'b1);
        kv0 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            kd0 = keyA[i];
            tick();
            if (i == 30) checkOutput("no_early_commit0", kc0, 1'b0);
        end
        kv0 = 1'b0;
        checkOutput("commit_pulse0", kc0, 1'b1);
        checkOutput("commit_ready0", kr0, 1'b0);
        checkOutput("commit_loaded_pre0", kl0, 1'b0);
        tick();
        checkOutput("commit_pulse_end0", kc0, 1'b0);
        checkOutput("loaded0", kl0, 1'b1);

        dv0 = 1'b1; din0 = 32'h0000_0000;
        tick();
        checkOutput("keyA_zero", dout0, 32'hA5A5_A5A5);
        din0 = 32'hFFFF_FFFF;
        tick();
        checkOutput("keyA_ones", dout0, 32'h5A5A_5A5A);

        // Interrupted reload with continuous data under the old key.
        din0 = 32'h1000_0001;
        ks0 = 1'b1;
        stream0(keyA);
        ks0 = 1'b0;
        kv0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            kd0 = keyB[i];
            stream0(keyA);
        end
        kv0 = 1'b0;
        ks0 = 1'b1;
        stream0(keyA);
        ks0 = 1'b0;
        checkOutput("restart_err", ke0, 1'b1);
        checkOutput("restart_ready", kr0, 1'b1);
        kv0 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            kd0 = keyB[i];
            stream0(keyA);
        end
        kv0 = 1'b0;
        checkOutput("reload_commit", kc0, 1'b1);
        checkOutput("reload_err_held", ke0, 1'b1);
        stream0(keyA);
        checkOutput("reload_err_clear", ke0, 1'b0);
        checkOutput("reload_loaded", kl0, 1'b1);
        stream0(keyB);
        stream0(keyB);
        dv0 = 1'b0;
        tick();
        checkOutput("stream_valid_off", ov0, 1'b0);

        // Wide, XNOR-masked, 3-stage instance, not yet keyed and not blanked.
        rst1 = 1'b0;
        #1;
        checkOutput("idle_ready1", kr1, 1'b0);
        checkOutput("rst_loaded1", kl1, 1'b0);
        checkOutput("rst_ovalid1", ov1, 1'b0);
        dv1 = 1'b1; din1 = 40'h00_0F0F_0F0F;
        tick();
        dv1 = 1'b0; din1 = '0;
        tick();
        checkOutput("pipe3_early", ov1, 1'b0);
        tick();
        checkOutput("pipe3_valid", ov1, 1'b1);
        checkOutput("xnor_zero_key", dout1, 40'hFF_F0F0_F0F0);
        dv1 = 1'b1; din1 = 40'h00_1234_5678;
        tick();
        dv1 = 1'b0;
        tick();
        tick();
        checkOutput("noblank_dout", dout1, 40'hFF_EDCB_A987);

        // Nibble load with a gap before every beat.
        ks1 = 1'b1;
        tick();
        ks1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            kv1 = 1'b0;
            tick();
            checkOutput("gap_ready1", kr1, 1'b1);
            kv1 = 1'b1;
            kd1 = keyN[4*i +: 4];
            tick();
            if (i < 7) checkOutput("no_early_commit1", kc1, 1'b0);
        end
        kv1 = 1'b0;
        checkOutput("commit_pulse1", kc1, 1'b1);
        checkOutput("commit_ready1", kr1, 1'b0);
        tick();
        checkOutput("loaded1", kl1, 1'b1);
        checkOutput("idle_ready1_post", kr1, 1'b0);

        dv1 = 1'b1; din1 = 40'h00_0000_0000;
        tick();
        din1 = 40'hFF_FFFF_FFFF;
        tick();
        dv1 = 1'b0;
        tick();
        checkOutput("wrap_zero", dout1, 40'hDE_789A_BCDE);
        tick();
        checkOutput("wrap_ones", dout1, 40'h21_8765_4321);

        // Reset with beats in flight flushes the pipe and drops the key.
        dv1 = 1'b1; din1 = 40'h11;
        tick();
        din1 = 40'h22;
        tick();
        din1 = 40'h33;
        tick();
        dv1 = 1'b0;
        rst1 = 1'b1;
        #1;
        checkOutput("midrst_ready", kr1, 1'b0);
        tick();
        rst1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("flush_valid", ov1, 1'b0);
            checkOutput("flush_dout", dout1, 40'h0);
            tick();
        end
        checkOutput("flush_loaded", kl1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
